ps2_mouse_packet_decoder: RTL and testbench

Downstream of the PS/2 serial core. Consumes the received byte stream (one strobe per byte) and assembles standard 3-byte PS/2 mouse packets. Outputs button state, signed 9-bit X/Y deltas and a clamped absolute cursor position in screen coordinates. Feeds the cursor overlay and the software-visible status registers.

---
 rtl/ps2_mouse_pkg.sv | 43 ++++
 rtl/ps2_axis_accum.sv | 50 +++++
 rtl/ps2_mouse_packet_decoder.sv | 131 +++++++++++++
 tb/tb_ps2_mouse_packet_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

  // Packet assembly state: which byte of the 3-byte packet is expected next.
  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } state_t;

  // Standard PS/2 mouse packet length in bytes.
  localparam int unsigned PKT_LEN = 3;

  // Byte-0 bit positions.
  localparam int unsigned B0_LEFT   = 0;
  localparam int unsigned B0_RIGHT  = 1;
  localparam int unsigned B0_MID    = 2;
  localparam int unsigned B0_SYNC   = 3;  // always 1 in a real header byte
  localparam int unsigned B0_X_SIGN = 4;
  localparam int unsigned B0_Y_SIGN = 5;
  localparam int unsigned B0_X_OVF  = 6;
  localparam int unsigned B0_Y_OVF  = 7;

  // Decoded packet fields as reported to software.
  typedef struct packed {
    logic [2:0] buttons;  // {middle, right, left}
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;      // {y_ovf, x_ovf}
  } pkt_t;

  // Split the three raw bytes into the reported fields.
  function automatic pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2);
    pkt_t p;
    p.buttons = {b0[B0_MID], b0[B0_RIGHT], b0[B0_LEFT]};
    p.dx      = {b0[B0_X_SIGN], b1};
    p.dy      = {b0[B0_Y_SIGN], b2};
    p.ovf     = {b0[B0_Y_OVF], b0[B0_X_OVF]};
    return p;
  endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: accumulates a signed 9-bit delta into a position register
// clamped to [0, MAX]. NEGATE subtracts the delta (used for screen Y).
module ps2_axis_accum
  import ps2_mouse_pkg::*;
#(
  parameter int MAX    = 639,
  parameter int W      = 10,
  parameter int INIT   = 319,
  parameter bit NEGATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [8:0]   delta,
  input  logic         en,
  input  logic         recenter,
  output logic [W-1:0] pos
);

  // Two extra bits: one for the sign, one so pos+delta cannot overflow.
  localparam int SW = W + 2;

  logic signed [SW-1:0] d_ext;
  logic signed [SW-1:0] pos_ext;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         pos_next;

  // Signed add/subtract then clamp into the screen range.
  always_comb begin
    d_ext   = {{(SW-9){delta[8]}}, delta};
    pos_ext = {2'b00, pos};
    sum     = NEGATE ? (pos_ext - d_ext) : (pos_ext + d_ext);
    if (sum < 0)
      pos_next = '0;
    else if (sum > $signed(SW'(MAX)))
      pos_next = W'(MAX);
    else
      pos_next = sum[W-1:0];
  end

  // Position register; recenter overrides a same-cycle update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pos <= W'(INIT);
    else if (recenter)
      pos <= W'(INIT);
    else if (en)
      pos <= pos_next;
  end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream, reports
// buttons/deltas/overflow and maintains a clamped absolute cursor position.
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int POS_W          = 10,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             recenter,
  output logic             pkt_valid,
  output logic [2:0]       buttons,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic [1:0]       ovf,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             sync_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Idle count at which the current idle cycle is the TIMEOUT_CYCLES-th one.
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                      state;
  logic [PKT_LEN-2:0][7:0]     pkt_buf;   // bytes 0 and 1; byte 2 is used on arrival
  logic [TW-1:0]               idle_cnt;
  pkt_t                        pkt_q;
  pkt_t                        pkt_next;
  logic                        pkt_fire;
  logic                        en_x;
  logic                        en_y;

  // Decode straight from the stored header plus the arriving third byte so
  // every output register loads on the edge that consumes byte 2.
  always_comb begin
    pkt_next = decode_pkt(pkt_buf[0], pkt_buf[1], rx_data);
    pkt_fire = rx_valid && (state == WAIT_B2);
    en_x     = pkt_fire && !pkt_buf[0][B0_X_OVF];
    en_y     = pkt_fire && !pkt_buf[0][B0_Y_OVF];
  end

  // Packet FSM with idle timeout and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_B0;
      pkt_buf   <= '0;
      idle_cnt  <= '0;
      pkt_q     <= '0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      case (state)
        WAIT_B0: begin
          idle_cnt <= '0;
          if (rx_valid) begin
            if (rx_data[B0_SYNC]) begin
              pkt_buf[0] <= rx_data;
              state      <= WAIT_B1;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        WAIT_B1, WAIT_B2: begin
          if (rx_valid) begin
            // A byte arriving on the timeout cycle is still accepted.
            idle_cnt <= '0;
            if (state == WAIT_B1) begin
              pkt_buf[1] <= rx_data;
              state      <= WAIT_B2;
            end else begin
              pkt_q     <= pkt_next;
              pkt_valid <= 1'b1;
              state     <= WAIT_B0;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            sync_err <= 1'b1;
            state    <= WAIT_B0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= WAIT_B0;
      endcase
    end
  end

  assign buttons = pkt_q.buttons;
  assign dx      = pkt_q.dx;
  assign dy      = pkt_q.dy;
  assign ovf     = pkt_q.ovf;

  ps2_axis_accum #(
    .MAX    (X_MAX),
    .W      (POS_W),
    .INIT   (X_MAX / 2),
    .NEGATE (1'b0)
  ) u_axis_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .delta    (pkt_next.dx),
    .en       (en_x),
    .recenter (recenter),
    .pos      (pos_x)
  );

  // PS/2 +Y is up while screen Y grows downward, hence the subtraction.
  ps2_axis_accum #(
    .MAX    (Y_MAX),
    .W      (POS_W),
    .INIT   (Y_MAX / 2),
    .NEGATE (1'b1)
  ) u_axis_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .delta    (pkt_next.dy),
    .en       (en_y),
    .recenter (recenter),
    .pos      (pos_y)
  );

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Bench for ps2_mouse_packet_decoder: vector table of packets with expected
// outputs pushed to a scoreboard queue, plus hand sequences for sync errors,
// timeout, reset mid-packet and recenter.
module tb_ps2_mouse_packet_decoder;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       recenter;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic [1:0] ovf;
  logic [9:0] pos_x, pos_y;
  logic       sync_err;

  ps2_mouse_packet_decoder #(
    .X_MAX(639), .Y_MAX(479), .POS_W(10), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .recenter(recenter), .pkt_valid(pkt_valid), .buttons(buttons), .dx(dx),
    .dy(dy), .ovf(ovf), .pos_x(pos_x), .pos_y(pos_y), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
    int         px;
    int         py;
  } exp_t;

  typedef struct {
    bit         rst;
    logic [7:0] b0, b1, b2;
    exp_t       e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   sync_cnt = 0;
  exp_t q[$];
  vec_t tbl[14];
  int   ntbl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] btn, input logic [8:0] edx,
                              input logic [8:0] edy, input logic [1:0] eovf,
                              input int px, input int py);
    exp_t e;
    e.btn = btn; e.dx = edx; e.dy = edy; e.ovf = eovf; e.px = px; e.py = py;
    return e;
  endfunction

  function automatic void add(input bit rst, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input exp_t e);
    tbl[ntbl].rst = rst;
    tbl[ntbl].b0 = b0; tbl[ntbl].b1 = b1; tbl[ntbl].b2 = b2;
    tbl[ntbl].e = e;
    ntbl++;
  endfunction

  // Scoreboard: every pkt_valid pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sync_err) sync_cnt++;
    if (pkt_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pkt: got pkt_valid=1 want no packet");
      end else begin
        e = q.pop_front();
        chk("buttons", 32'(buttons), 32'(e.btn));
        chk("dx",      32'(dx),      32'(e.dx));
        chk("dy",      32'(dy),      32'(e.dy));
        chk("ovf",     32'(ovf),     32'(e.ovf));
        chk("pos_x",   32'(pos_x),   32'(e.px));
        chk("pos_y",   32'(pos_y),   32'(e.py));
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; rx_valid = 1'b0; recenter = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Byte occupies the cycle starting at the current negedge.
  task automatic send(input logic [7:0] b, input bit rec);
    rx_data = b; rx_valid = 1'b1; recenter = rec;
    @(negedge clk);
    rx_valid = 1'b0; recenter = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit rec, input int gap, input exp_t e);
    send(b0, 1'b0);
    repeat (gap) @(negedge clk);
    send(b1, 1'b0);
    repeat (gap) @(negedge clk);
    q.push_back(e);
    send(b2, rec);
    chk("latency_pkt_valid", 32'(pkt_valid), 32'd1);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL pkt_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset_n = 1'b0; rx_valid = 1'b0; recenter = 1'b0; rx_data = 8'h00;

    add(1, 8'h09, 8'h05, 8'h03, mk(3'b001, 9'd5,     9'd3,     2'b00, 324, 236));
    add(1, 8'h38, 8'hF6, 8'hFE, mk(3'b000, 9'h1F6,   9'h1FE,   2'b00, 309, 241));
    add(1, 8'h08, 8'h7F, 8'h00, mk(3'b000, 9'h07F,   9'h000,   2'b00, 446, 239));
    add(0, 8'h08, 8'h7F, 8'h00, mk(3'b000, 9'h07F,   9'h000,   2'b00, 573, 239));
    add(0, 8'h08, 8'h7F, 8'h00, mk(3'b000, 9'h07F,   9'h000,   2'b00, 639, 239));
    add(0, 8'h08, 8'h7F, 8'h00, mk(3'b000, 9'h07F,   9'h000,   2'b00, 639, 239));
    add(0, 8'h48, 8'h7F, 8'h00, mk(3'b000, 9'h07F,   9'h000,   2'b01, 639, 239));
    add(0, 8'h0F, 8'h00, 8'h80, mk(3'b111, 9'h000,   9'h080,   2'b00, 639, 111));
    add(0, 8'h98, 8'h02, 8'h50, mk(3'b000, 9'h102,   9'h050,   2'b10, 385, 111));
    add(0, 8'h08, 8'h00, 8'h7F, mk(3'b000, 9'h000,   9'h07F,   2'b00, 385, 0));
    add(0, 8'h28, 8'h00, 8'h01, mk(3'b000, 9'h000,   9'h101,   2'b00, 385, 255));
    add(0, 8'h28, 8'h00, 8'h01, mk(3'b000, 9'h000,   9'h101,   2'b00, 385, 479));
    add(0, 8'h18, 8'h00, 8'h00, mk(3'b000, 9'h100,   9'h000,   2'b00, 129, 479));
    add(0, 8'h18, 8'h00, 8'h00, mk(3'b000, 9'h100,   9'h000,   2'b00, 0,   479));

    // Reset state
    do_reset();
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_sync_err",  32'(sync_err),  32'd0);
    chk("rst_buttons",   32'(buttons),   32'd0);
    chk("rst_dx",        32'(dx),        32'd0);
    chk("rst_dy",        32'(dy),        32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_pos_x",     32'(pos_x),     32'd319);
    chk("rst_pos_y",     32'(pos_y),     32'd239);

    // Vector table; gap 0 gives back-to-back strobes
    s0 = sync_cnt;
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].rst) do_reset();
      send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2, 1'b0, i % 3, tbl[i].e);
    end
    chk("table_no_sync_err", 32'(sync_cnt - s0), 32'd0);

    // Stray byte without the sync bit is discarded
    do_reset();
    send(8'h00, 1'b0);
    chk("stray_sync_err", 32'(sync_err), 32'd1);
    @(negedge clk);
    chk("stray_sync_err_pulse", 32'(sync_err), 32'd0);
    send_pkt(8'h08, 8'h01, 8'h01, 1'b0, 0, mk(3'b000, 9'd1, 9'd1, 2'b00, 320, 238));

    // Timeout inside a packet
    do_reset();
    send(8'h08, 1'b0);
    send(8'h10, 1'b0);
    repeat (T - 1) @(negedge clk);
    chk("timeout_not_early", 32'(sync_err), 32'd0);
    @(negedge clk);
    chk("timeout_sync_err", 32'(sync_err), 32'd1);
    send_pkt(8'h08, 8'h01, 8'h00, 1'b0, 0, mk(3'b000, 9'd1, 9'd0, 2'b00, 320, 239));

    // Byte on the timeout cycle wins
    do_reset();
    s0 = sync_cnt;
    send(8'h08, 1'b0);
    repeat (T - 1) @(negedge clk);
    send(8'h01, 1'b0);
    repeat (T - 1) @(negedge clk);
    q.push_back(mk(3'b000, 9'd1, 9'd0, 2'b00, 320, 239));
    send(8'h00, 1'b0);
    chk("edge_latency_pkt_valid", 32'(pkt_valid), 32'd1);
    repeat (2) @(negedge clk);
    chk("edge_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
    chk("edge_no_sync_err", 32'(sync_cnt - s0), 32'd0);

    // Reset mid-packet discards the partial packet
    send(8'h08, 1'b0);
    send(8'h7F, 1'b0);
    do_reset();
    send_pkt(8'h09, 8'h05, 8'h03, 1'b0, 0, mk(3'b001, 9'd5, 9'd3, 2'b00, 324, 236));

    // Standalone recenter
    recenter = 1'b1;
    @(negedge clk);
    recenter = 1'b0;
    chk("recenter_pos_x", 32'(pos_x), 32'd319);
    chk("recenter_pos_y", 32'(pos_y), 32'd239);

    // Recenter on the packet-update cycle
    send_pkt(8'h09, 8'h05, 8'h03, 1'b0, 1, mk(3'b001, 9'd5, 9'd3, 2'b00, 324, 236));
    send_pkt(8'h08, 8'h05, 8'h00, 1'b1, 0, mk(3'b000, 9'd5, 9'd0, 2'b00, 319, 239));

    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
